// File: rtl/pipe_seq_ctrl.sv
// rtl/pipe_seq_ctrl.sv - pipeline sequencer and hazard controller (optional STALL_CNT_EN adds stall_cnt)
module pipe_seq_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int REG_W        = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_run,
  input  logic             cmd_step,
  input  logic             cmd_stop,
  input  logic             halt_detect,
  input  logic             ID_EX_MemRead,
  input  logic [REG_W-1:0] ID_EX_rt,
  input  logic [REG_W-1:0] IF_ID_rs,
  input  logic [REG_W-1:0] IF_ID_rt,
  input  logic             branch_taken,
  output logic             db_ena,
  output logic             PC_Wr,
  output logic             IF_ID_Wr,
  output logic             IF_Flush,
  output logic             ctrl_zero,
  output logic             done,
  output logic [2:0]       state,
  output logic [31:0]      cycle_cnt
`ifdef STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Drain counter is loaded with one less than the drain length: the cycle
  // that observes zero is itself the last enabled drain cycle.
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t     cur;
  logic [3:0] drain_cnt;
  logic       load_use;

  assign state = cur;

  // Sequencer FSM with db_ena/done registered alongside the state transition
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur       <= S_IDLE;
      drain_cnt <= '0;
      db_ena    <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (cur)
        S_IDLE: begin
          if (cmd_run) begin
            cur    <= S_RUN;
            db_ena <= 1'b1;
          end else if (cmd_step) begin
            cur    <= S_STEP;
            db_ena <= 1'b1;
          end
        end
        S_RUN: begin
          if (halt_detect) begin
            cur       <= S_DRAIN;
            drain_cnt <= DRAIN_LOAD;
            db_ena    <= 1'b1;
          end else if (cmd_stop) begin
            cur    <= S_IDLE;
            db_ena <= 1'b0;
          end
        end
        S_STEP: begin
          // A step that fetches the end-of-program marker still drains the pipe
          if (halt_detect) begin
            cur       <= S_DRAIN;
            drain_cnt <= DRAIN_LOAD;
            db_ena    <= 1'b1;
          end else begin
            cur    <= S_IDLE;
            db_ena <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 4'd0) begin
            cur    <= S_DONE;
            db_ena <= 1'b0;
            done   <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        S_DONE: begin
          db_ena <= 1'b0;
          done   <= 1'b1;
        end
        default: begin
          cur    <= S_IDLE;
          db_ena <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

  // Load-use hazard: a load in EX targets a non-zero register read in ID
  always_comb begin
    load_use = ID_EX_MemRead && (ID_EX_rt != '0) &&
               ((ID_EX_rt == IF_ID_rs) || (ID_EX_rt == IF_ID_rt));
  end

  // Stall/bubble/flush decode; stall beats branch flush so the branch re-resolves
  always_comb begin
    IF_ID_Wr  = ~load_use;
    ctrl_zero = load_use;
    PC_Wr     = ~load_use && (cur != S_DRAIN);
    IF_Flush  = branch_taken && ~load_use;
  end

  // Enabled-cycle counter, free-wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cycle_cnt <= '0;
    else if (db_ena) cycle_cnt <= cycle_cnt + 32'd1;
  end

`ifdef STALL_CNT_EN
  // Saturating count of enabled cycles spent in a load-use stall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt <= '0;
    else if (db_ena && load_use && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// tb/tb_pipe_seq_ctrl.sv - self-checking bench for pipe_seq_ctrl
module tb_pipe_seq_ctrl;
  localparam int DC = 4;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_run = 1'b0, cmd_step = 1'b0, cmd_stop = 1'b0, halt_detect = 1'b0;
  logic          ID_EX_MemRead = 1'b0, branch_taken = 1'b0;
  logic [RW-1:0] ID_EX_rt = '0, IF_ID_rs = '0, IF_ID_rt = '0;
  logic          db_ena, PC_Wr, IF_ID_Wr, IF_Flush, ctrl_zero, done;
  logic [2:0]    state;
  logic [31:0]   cycle_cnt;
`ifdef STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  pipe_seq_ctrl #(.DRAIN_CYCLES(DC), .REG_W(RW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_stop(cmd_stop),
    .halt_detect(halt_detect), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rt(ID_EX_rt),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .branch_taken(branch_taken),
    .db_ena(db_ena), .PC_Wr(PC_Wr), .IF_ID_Wr(IF_ID_Wr), .IF_Flush(IF_Flush),
    .ctrl_zero(ctrl_zero), .done(done), .state(state), .cycle_cnt(cycle_cnt)
`ifdef STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int ena_seen = 0;
  int drain_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: running / pending-step flags, remaining drain cycles, done flag
  bit          m_run, m_step, m_done;
  int          m_drain;
  logic [31:0] m_cnt;
  int          m_stall;

  function automatic logic [2:0] m_state();
    if (m_done) return 3'd4;
    if (m_drain > 0) return 3'd3;
    if (m_step) return 3'd2;
    if (m_run) return 3'd1;
    return 3'd0;
  endfunction

  function automatic bit m_ena();
    return !m_done && (m_drain > 0 || m_step || m_run);
  endfunction

  function automatic bit m_lu();
    return ID_EX_MemRead && ID_EX_rt != 0 && (ID_EX_rt == IF_ID_rs || ID_EX_rt == IF_ID_rt);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run = 0; m_step = 0; m_done = 0; m_drain = 0; m_cnt = 0; m_stall = 0;
    end else begin
      if (m_ena()) begin
        m_cnt = m_cnt + 1;
        if (m_lu() && m_stall < 16'hFFFF) m_stall = m_stall + 1;
      end
      if (m_done) begin
      end else if (m_drain > 0) begin
        m_drain = m_drain - 1;
        if (m_drain == 0) m_done = 1;
      end else if (m_step) begin
        m_step = 0;
        if (halt_detect) m_drain = DC;
      end else if (m_run) begin
        if (halt_detect) begin m_run = 0; m_drain = DC; end
        else if (cmd_stop) m_run = 0;
      end else begin
        if (cmd_run) m_run = 1;
        else if (cmd_step) m_step = 1;
      end
    end
  end

  always @(negedge clk) begin
    check("db_ena", 32'(db_ena), 32'(m_ena()));
    check("state", 32'(state), 32'(m_state()));
    check("done", 32'(done), 32'(m_done));
    check("cycle_cnt", cycle_cnt, m_cnt);
    check("IF_ID_Wr", 32'(IF_ID_Wr), 32'(!m_lu()));
    check("ctrl_zero", 32'(ctrl_zero), 32'(m_lu()));
    check("PC_Wr", 32'(PC_Wr), 32'(!m_lu() && m_state() != 3'd3));
    check("IF_Flush", 32'(IF_Flush), 32'(branch_taken && !m_lu()));
`ifdef STALL_CNT_EN
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    if (db_ena) ena_seen++;
    if (state == 3'd3) drain_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    #3;
    check("reset state", 32'(state), 32'd0);
    check("reset db_ena", 32'(db_ena), 32'd0);
    check("reset cycle_cnt", cycle_cnt, 32'd0);
    check("reset done", 32'(done), 32'd0);
    @(negedge clk); #1 reset_n = 1'b1;

    // Run, halt after 10 enabled cycles, drain 4, done
    tick();
    ena_seen = 0; drain_seen = 0;
    cmd_run = 1; tick(); cmd_run = 0;
    repeat (9) tick();
    halt_detect = 1; tick(); halt_detect = 0;
    repeat (6) tick();
    check("run_halt ena cycles", 32'(ena_seen), 32'd14);
    check("run_halt drain cycles", 32'(drain_seen), 32'd4);
    check("run_halt cycle_cnt", cycle_cnt, 32'd14);
    check("run_halt done", 32'(done), 32'd1);
    check("run_halt db_ena", 32'(db_ena), 32'd0);
    check("run_halt state", 32'(state), 32'd4);

    // Commands in DONE are ignored
    cmd_run = 1; cmd_step = 1; tick(); cmd_run = 0; cmd_step = 0;
    cmd_stop = 1; tick(); cmd_stop = 0; tick();
    check("done sticky state", 32'(state), 32'd4);
    check("done sticky cnt", cycle_cnt, 32'd14);

    // Single step x3, one extra step pulse during STEP dropped
    reset_n = 0; #1;
    check("reset2 cycle_cnt", cycle_cnt, 32'd0);
    @(negedge clk); #1 reset_n = 1'b1;
    tick();
    ena_seen = 0;
    cmd_step = 1; tick(); tick(); cmd_step = 0;
    repeat (4) tick();
    for (int k = 0; k < 2; k++) begin
      cmd_step = 1; tick(); cmd_step = 0;
      repeat (4) tick();
    end
    check("step ena pulses", 32'(ena_seen), 32'd3);
    check("step cycle_cnt", cycle_cnt, 32'd3);
    check("step state", 32'(state), 32'd0);

    // Hazard decode (valid in IDLE too)
    ID_EX_MemRead = 1; ID_EX_rt = 5'd8; IF_ID_rs = 5'd8; IF_ID_rt = 5'd3; #1;
    check("lu IF_ID_Wr", 32'(IF_ID_Wr), 32'd0);
    check("lu PC_Wr", 32'(PC_Wr), 32'd0);
    check("lu ctrl_zero", 32'(ctrl_zero), 32'd1);
    IF_ID_rs = 5'd2; IF_ID_rt = 5'd8; #1;
    check("lu via rt ctrl_zero", 32'(ctrl_zero), 32'd1);
    ID_EX_rt = 5'd0; IF_ID_rs = 5'd0; IF_ID_rt = 5'd0; #1;
    check("r0 no stall IF_ID_Wr", 32'(IF_ID_Wr), 32'd1);
    check("r0 no stall PC_Wr", 32'(PC_Wr), 32'd1);
    check("r0 no stall ctrl_zero", 32'(ctrl_zero), 32'd0);
    branch_taken = 1; #1;
    check("branch flush", 32'(IF_Flush), 32'd1);
    ID_EX_rt = 5'd9; IF_ID_rs = 5'd9; #1;
    check("branch vs stall flush", 32'(IF_Flush), 32'd0);
    check("branch vs stall IF_ID_Wr", 32'(IF_ID_Wr), 32'd0);
    ID_EX_MemRead = 0; branch_taken = 0; ID_EX_rt = 0; IF_ID_rs = 0;
    tick();

    // Priorities: run beats step; halt beats stop
    cmd_run = 1; cmd_step = 1; tick(); cmd_run = 0; cmd_step = 0;
    check("run over step", 32'(state), 32'd1);
    ID_EX_MemRead = 1; ID_EX_rt = 5'd4; IF_ID_rt = 5'd4;
    repeat (3) tick();
    ID_EX_MemRead = 0; ID_EX_rt = 0; IF_ID_rt = 0;
`ifdef STALL_CNT_EN
    check("stall_cnt after 3", 32'(stall_cnt), 32'd3);
`endif
    branch_taken = 1; tick(); branch_taken = 0;
    cmd_stop = 1; halt_detect = 1; tick(); cmd_stop = 0; halt_detect = 0;
    check("halt over stop", 32'(state), 32'd3);
    tick();

    // Async reset mid-DRAIN, between edges
    #1 reset_n = 0; #1;
    check("async rst state", 32'(state), 32'd0);
    check("async rst db_ena", 32'(db_ena), 32'd0);
    check("async rst cycle_cnt", cycle_cnt, 32'd0);
`ifdef STALL_CNT_EN
    check("async rst stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    @(negedge clk); #1 reset_n = 1'b1;

    // Relaunch, run 4 cycles, stop
    tick();
    cmd_run = 1; tick(); cmd_run = 0;
    repeat (3) tick();
    cmd_stop = 1; tick(); cmd_stop = 0; tick();
    check("relaunch state", 32'(state), 32'd0);
    check("relaunch cycle_cnt", cycle_cnt, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
